// File: rtl/arr_check_sched_if.sv
// Handshake/status bundle for arr_check_sched: sweep request, lane strobes,
// per-lane compare results and the sweep result registers.
interface arr_check_sched_if #(
  parameter int NLANES = 6,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [NLANES-1:0] lane_en;
  logic [NLANES-1:0] mismatch_in;
  logic [NLANES-1:0] check;
  logic [2:0]        lane_sel;
  logic              busy;
  logic              done;
  logic [NLANES-1:0] err_mask;
  logic [CNT_W-1:0]  pass_count;
  logic [CNT_W-1:0]  fail_count;

  modport master (
    output start, lane_en, mismatch_in,
    input  check, lane_sel, busy, done, err_mask, pass_count, fail_count
  );

  modport slave (
    input  start, lane_en, mismatch_in,
    output check, lane_sel, busy, done, err_mask, pass_count, fail_count
  );
endinterface

// File: rtl/arr_check_sched.sv
// Array check scheduler: walks the enabled lanes one at a time, pulses a
// one-hot check strobe, waits SETTLE cycles, samples the lane's mismatch
// result and accumulates err_mask plus saturating pass/fail counters.
// Optional build macro ARR_CHECK_SCHED_STOP_ON_FAIL_EN: the first failing
// sample ends the sweep immediately.
module arr_check_sched #(
  parameter int NLANES = 6,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            reset_l,
  arr_check_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [2:0] LAST_LANE   = 3'(NLANES - 1);

  state_t            r_state;
  logic [NLANES-1:0] r_en;
  logic [NLANES-1:0] r_check;
  logic [NLANES-1:0] r_err;
  logic [2:0]        r_lane_sel;
  logic [3:0]        r_settle_cnt;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_pass;
  logic [CNT_W-1:0]  r_fail;

  logic [2:0]        w_next_lane;
  logic [NLANES-1:0] w_next_check;
  logic              w_last;
  logic              w_mm;
  logic              w_stop;
  logic              w_adv;

  // Next-lane bookkeeping shared by the skipped-lane and post-sample paths
  always_comb begin
    w_next_lane  = r_lane_sel + 3'd1;
    w_last       = (r_lane_sel == LAST_LANE);
    w_mm         = bus.mismatch_in[r_lane_sel];
    w_next_check = '0;
    if (!w_last && r_en[w_next_lane]) begin
      w_next_check = NLANES'(1) << w_next_lane;
    end
`ifdef ARR_CHECK_SCHED_STOP_ON_FAIL_EN
    w_stop = w_mm;
`else
    w_stop = 1'b0;
`endif
    w_adv = ((r_state == S_ISSUE) && !r_en[r_lane_sel]) ||
            ((r_state == S_SAMPLE) && !w_stop);
  end

  // Sweep FSM; check/done are registered so the strobe lines up with ISSUE/DONE
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state      <= S_IDLE;
      r_en         <= '0;
      r_check      <= '0;
      r_err        <= '0;
      r_lane_sel   <= '0;
      r_settle_cnt <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= '0;
      r_fail       <= '0;
    end else begin
      r_check <= '0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_ISSUE;
            r_lane_sel <= '0;
            r_en       <= bus.lane_en;
            r_err      <= '0;
            r_pass     <= '0;
            r_fail     <= '0;
            r_busy     <= 1'b1;
            r_check    <= NLANES'(bus.lane_en[0]);
          end
        end
        S_ISSUE: begin
          if (r_en[r_lane_sel]) begin
            if (SETTLE > 0) begin
              r_state      <= S_SETTLE;
              r_settle_cnt <= SETTLE_INIT;
            end else begin
              r_state <= S_SAMPLE;
            end
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == 4'd0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (w_mm) begin
            r_err[r_lane_sel] <= 1'b1;
            if (r_fail != '1) r_fail <= r_fail + 1'b1;
          end else begin
            if (r_pass != '1) r_pass <= r_pass + 1'b1;
          end
          if (w_stop) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
      // Skipped lanes and completed samples share one advance path; the
      // next lane's strobe is loaded here so it appears in its ISSUE cycle.
      if (w_adv) begin
        if (w_last) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end else begin
          r_state    <= S_ISSUE;
          r_lane_sel <= w_next_lane;
          r_check    <= w_next_check;
        end
      end
    end
  end

  assign bus.check      = r_check;
  assign bus.lane_sel   = r_lane_sel;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err_mask   = r_err;
  assign bus.pass_count = r_pass;
  assign bus.fail_count = r_fail;

endmodule
